// File: rtl/vga_pattern_gen.sv
// Test-pattern generator sitting behind an upstream video timing generator.
// Syncs are re-timed by two stages so they stay aligned with the generated pixel.
module vga_pattern_gen #(
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int V_POLARITY = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        de_i,
    input  logic [1:0]  mode_i,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic [23:0] rgb_o
);

    localparam logic        VPOL   = 1'(V_POLARITY != 0);
    localparam int          BAR_W  = H_ACTIVE / 8;
    localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0] BX_LIM = 11'(H_ACTIVE - 64);
    localparam logic [10:0] BY_LIM = 11'(V_ACTIVE - 64);

    typedef enum logic [1:0] {M_BARS, M_CHECK, M_GRAD, M_BOX} mode_e;

    // Raster state
    logic        vs_prev_q, de_prev_q;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    mode_e       mode_q, mode_d;

    // Bouncing box state; *_dn_q = 1 means moving towards 0
    logic [10:0] box_x_q, box_x_d;
    logic [10:0] box_y_q, box_y_d;
    logic        box_x_dn_q, box_x_dn_d;
    logic        box_y_dn_q, box_y_dn_d;

    // Pipeline stage 1 and output stage
    logic        hs1_q, vs1_q, de1_q;
    logic [23:0] rgb1_q, rgb1_d;
    logic        hs2_q, vs2_q, de2_q;
    logic [23:0] rgb2_q;

    logic        frame_start;
    logic [2:0]  bar;
    logic        in_box;
    logic [23:0] pix;

    // Reaching a bound clamps there and flips direction, so the next frame steps away.
    function automatic logic [11:0] box_step(input logic [10:0] pos, input logic dn,
                                             input logic [10:0] stp, input logic [10:0] lim);
        logic [11:0] r;
        if (!dn) begin
            if (({1'b0, pos} + {1'b0, stp}) >= {1'b0, lim}) r = {1'b1, lim};
            else                                               r = {1'b0, pos + stp};
        end else begin
            if (pos <= stp) r = {1'b0, 11'd0};
            else            r = {1'b1, pos - stp};
        end
        return r;
    endfunction

    assign frame_start = (vsync_i == VPOL) && (vs_prev_q != VPOL);

    always_comb begin
        x_d = '0;
        if (de_i) x_d = (x_q == X_LAST) ? x_q : x_q + 11'd1;

        y_d = y_q;
        if (frame_start)
            y_d = '0;
        else if (de_prev_q && !de_i && (y_q != Y_LAST))
            y_d = y_q + 11'd1;

        mode_d = frame_start ? mode_e'(mode_i) : mode_q;

        {box_x_dn_d, box_x_d} = {box_x_dn_q, box_x_q};
        {box_y_dn_d, box_y_d} = {box_y_dn_q, box_y_q};
        if (frame_start) begin
            {box_x_dn_d, box_x_d} = box_step(box_x_q, box_x_dn_q, 11'd4, BX_LIM);
            {box_y_dn_d, box_y_d} = box_step(box_y_q, box_y_dn_q, 11'd2, BY_LIM);
        end
    end

    // Bar index from constant boundary compares instead of a divide
    always_comb begin
        bar = '0;
        for (int k = 1; k < 8; k++)
            if (x_q >= 11'(k * BAR_W)) bar = 3'(k);
    end

    assign in_box = (x_q >= box_x_q) && ({1'b0, x_q} < ({1'b0, box_x_q} + 12'd64)) &&
                    (y_q >= box_y_q) && ({1'b0, y_q} < ({1'b0, box_y_q} + 12'd64));

    always_comb begin
        pix = 24'h000000;
        case (mode_q)
            M_BARS: begin
                case (bar)
                    3'd0:    pix = 24'hFFFFFF;
                    3'd1:    pix = 24'hFFFF00;
                    3'd2:    pix = 24'h00FFFF;
                    3'd3:    pix = 24'h00FF00;
                    3'd4:    pix = 24'hFF00FF;
                    3'd5:    pix = 24'hFF0000;
                    3'd6:    pix = 24'h0000FF;
                    default: pix = 24'h000000;
                endcase
            end
            M_CHECK: pix = (x_q[5] ^ y_q[5]) ? 24'hFFFFFF : 24'h000000;
            M_GRAD:  pix = {3{x_q[7:0]}};
            default: pix = in_box ? 24'hFFFFFF : 24'h0000FF;
        endcase
        rgb1_d = de_i ? pix : 24'h000000;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vs_prev_q  <= VPOL;
            de_prev_q  <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            mode_q     <= M_BARS;
            box_x_q    <= '0;
            box_y_q    <= '0;
            box_x_dn_q <= 1'b0;
            box_y_dn_q <= 1'b0;
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            de1_q      <= 1'b0;
            rgb1_q     <= '0;
            hs2_q      <= 1'b0;
            vs2_q      <= 1'b0;
            de2_q      <= 1'b0;
            rgb2_q     <= '0;
        end else begin
            vs_prev_q  <= vsync_i;
            de_prev_q  <= de_i;
            x_q        <= x_d;
            y_q        <= y_d;
            mode_q     <= mode_d;
            box_x_q    <= box_x_d;
            box_y_q    <= box_y_d;
            box_x_dn_q <= box_x_dn_d;
            box_y_dn_q <= box_y_dn_d;
            hs1_q      <= hsync_i;
            vs1_q      <= vsync_i;
            de1_q      <= de_i;
            rgb1_q     <= rgb1_d;
            hs2_q      <= hs1_q;
            vs2_q      <= vs1_q;
            de2_q      <= de1_q;
            rgb2_q     <= rgb1_q;
        end
    end

    assign hsync_o = hs2_q;
    assign vsync_o = vs2_q;
    assign de_o    = de2_q;
    assign rgb_o   = rgb2_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: per-cycle comparison against a pixel-level model,
// plus directed line/frame scenarios with hand-computed pixel values.
module tb_vga_pattern_gen;

    localparam int H = 1280;
    localparam int V = 720;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        hsync_i = 1'b0, vsync_i = 1'b0, de_i = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic        hsync_o, vsync_o, de_o;
    logic [23:0] rgb_o;

    vga_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .V_POLARITY(1)) dut (
        .clk(clk), .rstn(rstn), .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i),
        .mode_i(mode_i), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .rgb_o(rgb_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference pixel rule written straight from the pattern definitions
    function automatic logic [23:0] pat(int m, int x, int y, int bx, int by);
        int b;
        case (m)
            0: begin
                b = x / (H / 8);
                if (b > 7) b = 7;
                case (b)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            1: return (((x / 32) + (y / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            2: return {3{8'(x % 256)}};
            default: return (x >= bx && x < bx + 64 && y >= by && y < by + 64) ? 24'hFFFFFF : 24'h0000FF;
        endcase
    endfunction

    // Model state
    int mx, my, mmode, mbx, mby;
    bit mbx_dn, mby_dn, mvs_prev, mde_prev;
    logic e1_hs, e1_vs, e1_de, e2_hs, e2_vs, e2_de;
    logic [23:0] e1_rgb, e2_rgb;

    // Observation state
    int cyc = 0, din_rise = 0, dout_rise = 0, ox = 0;
    bit mon_prev = 1'b0;
    logic [23:0] line_buf [2048];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rstn) begin
                mx = 0; my = 0; mmode = 0; mbx = 0; mby = 0;
                mbx_dn = 0; mby_dn = 0; mvs_prev = 1; mde_prev = 0;
                {e1_hs, e1_vs, e1_de, e1_rgb} = '0;
                {e2_hs, e2_vs, e2_de, e2_rgb} = '0;
            end else begin
                {e2_hs, e2_vs, e2_de, e2_rgb} = {e1_hs, e1_vs, e1_de, e1_rgb};
                e1_hs = hsync_i; e1_vs = vsync_i; e1_de = de_i;
                e1_rgb = de_i ? pat(mmode, mx, my, mbx, mby) : 24'h000000;
                if (de_i && !mde_prev) din_rise = cyc;
                if (vsync_i && !mvs_prev) begin
                    my = 0;
                    mmode = int'(mode_i);
                    if (!mbx_dn) begin
                        if (mbx + 4 >= H - 64) begin mbx = H - 64; mbx_dn = 1; end else mbx += 4;
                    end else begin
                        if (mbx - 4 <= 0) begin mbx = 0; mbx_dn = 0; end else mbx -= 4;
                    end
                    if (!mby_dn) begin
                        if (mby + 2 >= V - 64) begin mby = V - 64; mby_dn = 1; end else mby += 2;
                    end else begin
                        if (mby - 2 <= 0) begin mby = 0; mby_dn = 0; end else mby -= 2;
                    end
                end else if (mde_prev && !de_i && my < V - 1) begin
                    my++;
                end
                mx = de_i ? ((mx + 1 > H - 1) ? H - 1 : mx + 1) : 0;
                mde_prev = de_i;
                mvs_prev = vsync_i;
            end
            #1;
            chk("hsync_o", 32'(hsync_o), 32'(e2_hs));
            chk("vsync_o", 32'(vsync_o), 32'(e2_vs));
            chk("de_o",    32'(de_o),    32'(e2_de));
            chk("rgb_o",   32'(rgb_o),   32'(e2_rgb));
            if (de_o) begin
                if (!mon_prev) begin ox = 0; dout_rise = cyc; end
                line_buf[ox] = rgb_o;
                if (ox < 2047) ox++;
            end
            mon_prev = de_o;
        end
    end

    task automatic drive(input logic hs, input logic vs, input logic de);
        @(negedge clk);
        hsync_i = hs; vsync_i = vs; de_i = de;
    endtask

    task automatic line(input int len);
        repeat (len) drive(0, 0, 1);
        repeat (2) drive(0, 0, 0);
        repeat (2) drive(1, 0, 0);
        repeat (2) drive(0, 0, 0);
    endtask

    task automatic lines_fast(input int n);
        repeat (n) begin drive(0, 0, 1); drive(0, 0, 0); end
    endtask

    task automatic frame();
        repeat (2) drive(0, 1, 0);
        repeat (2) drive(0, 0, 0);
    endtask

    function automatic int first_white(input int len);
        for (int i = 0; i < len; i++)
            if (line_buf[i] == 24'hFFFFFF) return i;
        return -1;
    endfunction

    int fw [10];

    initial begin
        // Reset state
        repeat (5) drive(0, 0, 0);
        chk("reset rgb_o",   32'(rgb_o),   32'h0);
        chk("reset de_o",    32'(de_o),    32'h0);
        chk("reset hsync_o", 32'(hsync_o), 32'h0);
        chk("reset vsync_o", 32'(vsync_o), 32'h0);
        rstn = 1'b1;

        // Before the first frame start the latched mode is bars
        mode_i = 2'd2;
        line(300);
        chk("pre-frame x0 bars",   32'(line_buf[0]),   32'hFFFFFF);
        chk("pre-frame x200 bars", 32'(line_buf[200]), 32'hFFFF00);

        // Bars
        mode_i = 2'd0;
        frame();
        line(1280);
        chk("bars x0",    32'(line_buf[0]),    32'hFFFFFF);
        chk("bars x159",  32'(line_buf[159]),  32'hFFFFFF);
        chk("bars x160",  32'(line_buf[160]),  32'hFFFF00);
        chk("bars x639",  32'(line_buf[639]),  32'h00FF00);
        chk("bars x1279", 32'(line_buf[1279]), 32'h000000);
        // de_i first presented in cycle din_rise-1, de_o first seen in cycle dout_rise
        chk("de_o latency", 32'(dout_rise - (din_rise - 1)), 32'd2);

        // Gradient wrap and x saturation on an over-long line
        mode_i = 2'd2;
        frame();
        line(1300);
        chk("grad x255",      32'(line_buf[255]),  32'hFFFFFF);
        chk("grad x256",      32'(line_buf[256]),  32'h000000);
        chk("grad x1279",     32'(line_buf[1279]), 32'hFFFFFF);
        chk("grad sat x1299", 32'(line_buf[1299]), 32'hFFFFFF);
        chk("blank rgb_o",    32'(rgb_o),          32'h0);

        // Mode change mid-frame only takes effect at the next frame start
        mode_i = 2'd0;
        frame();
        line(300);
        mode_i = 2'd2;
        line(300);
        chk("midframe x0 bars",   32'(line_buf[0]),   32'hFFFFFF);
        chk("midframe x200 bars", 32'(line_buf[200]), 32'hFFFF00);
        frame();
        line(300);
        chk("next frame x200 grad", 32'(line_buf[200]), 32'hC8C8C8);

        // Checker
        mode_i = 2'd1;
        frame();
        line(40);
        chk("checker (0,0)",  32'(line_buf[0]),  32'h000000);
        chk("checker (31,0)", 32'(line_buf[31]), 32'h000000);
        chk("checker (32,0)", 32'(line_buf[32]), 32'hFFFFFF);
        repeat (31) line(40);
        line(40);
        chk("checker (32,32)", 32'(line_buf[32]), 32'h000000);
        chk("checker (0,32)",  32'(line_buf[0]),  32'hFFFFFF);

        // Reset in the middle of a line
        repeat (10) drive(0, 0, 1);
        rstn = 1'b0;
        drive(0, 0, 1);
        chk("midline reset de_o",  32'(de_o),  32'h0);
        chk("midline reset rgb_o", 32'(rgb_o), 32'h0);
        repeat (2) drive(0, 0, 0);
        rstn = 1'b1;
        repeat (3) drive(0, 0, 0);
        chk("post-release de_o",  32'(de_o),  32'h0);
        chk("post-release rgb_o", 32'(rgb_o), 32'h0);

        // Box: after f frame starts since reset, box at (4f, 2f)
        mode_i = 2'd3;
        for (int f = 1; f <= 3; f++) begin
            frame();
            for (int l = 0; l < 10; l++) begin
                line(80);
                fw[l] = first_white(80);
            end
            chk($sformatf("box_x frame %0d", f), 32'(fw[2 * f]), 32'(4 * f));
            chk($sformatf("above box frame %0d", f), 32'(fw[2 * f - 1]), 32'hFFFFFFFF);
        end
        // 303 starts put box_x at 1212; then 1216 (bound), then back to 1212
        repeat (300) frame();
        frame();
        lines_fast(620);
        line(1280);
        chk("box_x at bound", 32'(first_white(1280)), 32'd1216);
        frame();
        lines_fast(620);
        line(1280);
        chk("box_x reversed", 32'(first_white(1280)), 32'd1212);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
